cr_kme_kop_keybuilder: RTL and testbench
========================================

CR_KME_KOP_KEYBUILDER -- requirements
Module: cr_kme_kop_keybuilder

Interface
REQ-001 SHALL have parameter KB_BEATS, default 12, meaning 64-bit beats per key record (8 DEK + 4 DAK).
REQ-002 SHALL have parameter DEK_BEATS, default 8, meaning leading beats that form the DEK.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port kdf_keybuilder_data, input, 64, key-material beat from the KDF merger.
REQ-006 SHALL have port kdf_keybuilder_valid, input, 1, beat present; the beat is consumed in any cycle where this is high.
REQ-007 SHALL have port keybuilder_kdf_stall, output, 1, backpressure to the merger.
REQ-008 SHALL have port kb_out_valid, output, 1, assembled record available.
REQ-009 SHALL have port kb_out_dek, output, 512, assembled DEK.
REQ-010 SHALL have port kb_out_dak, output, 256, assembled DAK.
REQ-011 SHALL have port kb_out_dek_zero, output, 1, DEK is all-zero (NOOP/bypass key).
REQ-012 SHALL have port kb_out_dak_zero, output, 1, DAK is all-zero.
REQ-013 SHALL have port kb_out_ack, input, 1, consumer takes the record this cycle; valid only while kb_out_valid is high.
REQ-014 SHALL have port kb_rec_count, output, 16, records delivered, wrapping.

Function
REQ-015 SHALL place beat n (0..7) at kb_out_dek[511-64n -: 64] and beat n (8..11) at kb_out_dak[255-64(n-8) -: 64], MSB first.
REQ-016 SHALL count accepted beats in a 4-bit counter acc_cnt: 0..KB_BEATS-1, wrapping to 0 after the last beat.
REQ-017 SHALL have assembly states FILL (acc_cnt counting) and FULL (12 beats held, output register busy).
REQ-018 SHALL, on the last beat in FILL, when the output register is empty or kb_out_ack is high that cycle, load the output register directly: kb_out_valid rises 1 cycle after the last beat, and the state stays FILL.
REQ-019 SHALL, on the last beat in FILL, when the output register is occupied and not acked, enter FULL.
REQ-020 SHALL in FULL, on kb_out_ack, transfer the assembly register to the output register and return to FILL; kb_out_valid stays high with no bubble.
REQ-021 SHALL drive keybuilder_kdf_stall from the registered state only (high exactly in FULL), never from kdf_keybuilder_valid, so no combinational loop forms with the merger.
REQ-022 SHALL ignore kdf_keybuilder_valid while in FULL; an arriving beat is a protocol error, is dropped, and sets no state.
REQ-023 SHALL compute the dek_zero and dak_zero flags during assembly: per-part flags are cleared on any nonzero beat of that part, are set at record start, and are registered with the record.
REQ-024 SHALL hold kb_out_valid and all kb_out_* fields stable until kb_out_ack.
REQ-025 SHALL clear kb_out_valid on kb_out_ack unless a new record is loaded in the same cycle (REQ-018/REQ-020).
REQ-026 SHALL increment kb_rec_count on each kb_out_valid & kb_out_ack, wrapping 0xFFFF to 0x0000.
REQ-027 SHALL give a sustained throughput of one record per 12 cycles when kb_out_ack is tied high.

Reset
REQ-028 SHALL on rst_n low asynchronously clear acc_cnt to 0, enter FILL, drive keybuilder_kdf_stall 0, kb_out_valid 0, kb_out_dek/dak 0, both zero flags 0, and kb_rec_count 0.
REQ-029 SHALL discard any partial record on reset mid-assembly; the first beat after reset is beat 0.

Structure
REQ-030 SHALL take KB_BEATS, DEK_BEATS and the typedef kb_rec_t {dek, dak, dek_zero, dak_zero} from cr_kme_body_param.v.
REQ-031 SHALL be a single module without sub-modules: one assembly register, one output register, and the counter/state logic.

Verification
REQ-032 SHALL cover: 12 beats 0x0..0xB back-to-back with kb_out_ack high -> kb_out_valid 1 cycle after beat 11, DEK beat0 = 0x0 in bits [511:448], DAK[63:0] = 0xB, both zero flags 0, kb_rec_count = 1.
REQ-033 SHALL cover: 8 zero DEK beats + 4 beats 0x5 -> dek_zero 1, dak_zero 0.
REQ-034 SHALL cover: kb_out_ack held low over two records -> stall rises after beat 23 (the second record's last beat); ack -> next cycle second record valid, stall 0, no bubble.
REQ-035 SHALL cover: 1000 records, ack tied high -> kb_rec_count = 1000, one record every 12 cycles, no data mismatch against the model.
REQ-036 SHALL cover: rst_n pulsed after beat 5 -> all outputs 0; the next 12 beats form a clean record.
REQ-037 SHALL cover: kb_rec_count preloaded to 0xFFFF (via 65535 records or force) plus one record -> 0x0000.

Source files
------------

// File: rtl/cr_kme_kop_keybuilder_pkg.sv
// Shared types and sizing for the KOP key builder: record layout and assembly states.
package cr_kme_kop_keybuilder_pkg;

  localparam int KB_BEAT_W        = 64;
  localparam int KB_BEATS_DEFAULT = 12;
  localparam int DEK_BEATS_DEFAULT = 8;
  localparam int KB_DEK_W         = DEK_BEATS_DEFAULT * KB_BEAT_W;
  localparam int KB_DAK_W         = (KB_BEATS_DEFAULT - DEK_BEATS_DEFAULT) * KB_BEAT_W;

  typedef struct packed {
    logic [KB_DEK_W-1:0] dek;
    logic [KB_DAK_W-1:0] dak;
    logic                dek_zero;
    logic                dak_zero;
  } kb_rec_t;

  typedef enum logic {
    KB_FILL = 1'b0,
    KB_FULL = 1'b1
  } kb_state_e;

endpackage

// File: rtl/cr_kme_kop_keybuilder.sv
// Assembles twelve 64-bit KDF beats into one DEK/DAK key record, with a
// one-deep output register and a held assembly register for backpressure.
module cr_kme_kop_keybuilder
  import cr_kme_kop_keybuilder_pkg::*;
#(
  parameter int KB_BEATS  = KB_BEATS_DEFAULT,
  parameter int DEK_BEATS = DEK_BEATS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  kdf_keybuilder_data,
  input  logic         kdf_keybuilder_valid,
  output logic         keybuilder_kdf_stall,
  output logic         kb_out_valid,
  output logic [511:0] kb_out_dek,
  output logic [255:0] kb_out_dak,
  output logic         kb_out_dek_zero,
  output logic         kb_out_dak_zero,
  input  logic         kb_out_ack,
  output logic [15:0]  kb_rec_count
);

  localparam int DAK_BEATS = KB_BEATS - DEK_BEATS;

  kb_state_e state_q, state_d;
  logic [3:0] acc_cnt;
  logic [3:0] beat_idx;
  logic       beat_acc, last_beat, is_dek_beat, beat_nz;
  logic       load_new, load_held;

  logic [KB_BEATS-1:0][KB_BEAT_W-1:0] asm_p0, asm_d;
  logic    dek_z_p0, dak_z_p0, dek_z_d, dak_z_d;
  kb_rec_t rec_new, rec_held, out_p1;
  logic    vld_p1;

  assign beat_acc    = kdf_keybuilder_valid && (state_q == KB_FILL);
  assign last_beat   = beat_acc && (acc_cnt == 4'(KB_BEATS - 1));
  assign beat_idx    = 4'(KB_BEATS - 1) - acc_cnt;
  assign is_dek_beat = (acc_cnt < 4'(DEK_BEATS));
  assign beat_nz     = |kdf_keybuilder_data;

  // Beat 0 lands in the most significant slot so the record reads MSB first.
  always_comb begin
    asm_d = asm_p0;
    asm_d[beat_idx] = kdf_keybuilder_data;
    dek_z_d = ((acc_cnt == 4'd0) ? 1'b1 : dek_z_p0) & ~(is_dek_beat & beat_nz);
    dak_z_d = ((acc_cnt == 4'd0) ? 1'b1 : dak_z_p0) & ~(~is_dek_beat & beat_nz);
  end

  always_comb begin
    rec_new.dek       = asm_d[KB_BEATS-1 -: DEK_BEATS];
    rec_new.dak       = asm_d[DAK_BEATS-1:0];
    rec_new.dek_zero  = dek_z_d;
    rec_new.dak_zero  = dak_z_d;
    rec_held.dek      = asm_p0[KB_BEATS-1 -: DEK_BEATS];
    rec_held.dak      = asm_p0[DAK_BEATS-1:0];
    rec_held.dek_zero = dek_z_p0;
    rec_held.dak_zero = dak_z_p0;
  end

  always_comb begin
    state_d   = state_q;
    load_new  = 1'b0;
    load_held = 1'b0;
    case (state_q)
      KB_FILL: begin
        if (last_beat) begin
          if (!vld_p1 || kb_out_ack) load_new = 1'b1;
          else                       state_d  = KB_FULL;
        end
      end
      KB_FULL: begin
        if (kb_out_ack) begin
          load_held = 1'b1;
          state_d   = KB_FILL;
        end
      end
      default: state_d = KB_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KB_FILL;
      acc_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      if (beat_acc) acc_cnt <= last_beat ? 4'd0 : acc_cnt + 4'd1;
    end
  end

  // Stage p0: assembly register, frozen while a finished record waits in FULL.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      asm_p0   <= asm_d;
      dek_z_p0 <= dek_z_d;
      dak_z_p0 <= dak_z_d;
    end
  end

  // Stage p1: output register, held stable until the consumer acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1       <= '0;
      vld_p1       <= 1'b0;
      kb_rec_count <= 16'd0;
    end else begin
      if (load_new)        out_p1 <= rec_new;
      else if (load_held)  out_p1 <= rec_held;
      if (load_new || load_held) vld_p1 <= 1'b1;
      else if (kb_out_ack)       vld_p1 <= 1'b0;
      if (vld_p1 && kb_out_ack)  kb_rec_count <= kb_rec_count + 16'd1;
    end
  end

  assign keybuilder_kdf_stall = (state_q == KB_FULL);
  assign kb_out_valid         = vld_p1;
  assign kb_out_dek           = out_p1.dek;
  assign kb_out_dak           = out_p1.dak;
  assign kb_out_dek_zero      = out_p1.dek_zero;
  assign kb_out_dak_zero      = out_p1.dak_zero;

endmodule

// File: tb/tb_cr_kme_kop_keybuilder.sv
// Scoreboard bench for the key builder: stimulus pushes expected records,
// a negedge monitor pops and compares on every valid/ack handshake.
module tb_cr_kme_kop_keybuilder;
  import cr_kme_kop_keybuilder_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  kdf_keybuilder_data = '0;
  logic         kdf_keybuilder_valid = 1'b0;
  logic         keybuilder_kdf_stall;
  logic         kb_out_valid;
  logic [511:0] kb_out_dek;
  logic [255:0] kb_out_dak;
  logic         kb_out_dek_zero;
  logic         kb_out_dak_zero;
  logic         kb_out_ack = 1'b0;
  logic [15:0]  kb_rec_count;

  cr_kme_kop_keybuilder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .kdf_keybuilder_data  (kdf_keybuilder_data),
    .kdf_keybuilder_valid (kdf_keybuilder_valid),
    .keybuilder_kdf_stall (keybuilder_kdf_stall),
    .kb_out_valid         (kb_out_valid),
    .kb_out_dek           (kb_out_dek),
    .kb_out_dak           (kb_out_dak),
    .kb_out_dek_zero      (kb_out_dek_zero),
    .kb_out_dak_zero      (kb_out_dak_zero),
    .kb_out_ack           (kb_out_ack),
    .kb_rec_count         (kb_rec_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  kb_rec_t sb[$];
  logic [63:0] cur [12];
  int  cyc = 0;
  bit  tput_on = 1'b0;
  int  last_hs = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic kb_rec_t model_cur();
    kb_rec_t r;
    r.dek = '0;
    r.dak = '0;
    for (int n = 0; n < 8; n++)  r.dek[511-64*n -: 64] = cur[n];
    for (int n = 8; n < 12; n++) r.dak[255-64*(n-8) -: 64] = cur[n];
    r.dek_zero = (r.dek == '0);
    r.dak_zero = (r.dak == '0);
    return r;
  endfunction

  // Drives n beats back-to-back starting one step after a rising edge.
  task automatic send_beats(input int n, input bit push);
    if (push) sb.push_back(model_cur());
    for (int i = 0; i < n; i++) begin
      kdf_keybuilder_valid = 1'b1;
      kdf_keybuilder_data  = cur[i];
      @(posedge clk); #1;
    end
    kdf_keybuilder_valid = 1'b0;
    kdf_keybuilder_data  = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && kb_out_valid && kb_out_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_record", 1, 0);
      end else begin
        kb_rec_t e;
        e = sb.pop_front();
        chk("rec_dek", kb_out_dek, e.dek);
        chk("rec_dak", 512'(kb_out_dak), 512'(e.dak));
        chk("rec_dek_zero", 512'(kb_out_dek_zero), 512'(e.dek_zero));
        chk("rec_dak_zero", 512'(kb_out_dak_zero), 512'(e.dak_zero));
      end
      if (tput_on) begin
        if (last_hs >= 0) chk("tput_spacing", 512'(cyc - last_hs), 512'd12);
        last_hs = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 512'(kb_out_valid), 0);
    chk("rst_stall", 512'(keybuilder_kdf_stall), 0);
    chk("rst_dek", kb_out_dek, 0);
    chk("rst_cnt", 512'(kb_rec_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Beats 0x0..0xB with ack high.
    kb_out_ack = 1'b1;
    for (int i = 0; i < 12; i++) cur[i] = 64'(i);
    send_beats(11, 1'b0);
    chk("seq_valid_early", 512'(kb_out_valid), 0);
    kdf_keybuilder_valid = 1'b1;
    kdf_keybuilder_data  = cur[11];
    sb.push_back(model_cur());
    @(posedge clk); #1;
    kdf_keybuilder_valid = 1'b0;
    chk("seq_valid", 512'(kb_out_valid), 1);
    chk("seq_dek_beat0", 512'(kb_out_dek[511:448]), 0);
    chk("seq_dek_beat1", 512'(kb_out_dek[447:384]), 1);
    chk("seq_dak_last", 512'(kb_out_dak[63:0]), 512'h0B);
    chk("seq_dek_zero", 512'(kb_out_dek_zero), 0);
    chk("seq_dak_zero", 512'(kb_out_dak_zero), 0);
    @(posedge clk); #1;
    chk("seq_cnt", 512'(kb_rec_count), 1);
    chk("seq_valid_clear", 512'(kb_out_valid), 0);

    // Zero DEK, DAK of 0x5.
    for (int i = 0; i < 12; i++) cur[i] = (i < 8) ? 64'h0 : 64'h5;
    send_beats(12, 1'b1);
    chk("zero_dek_flag", 512'(kb_out_dek_zero), 1);
    chk("zero_dak_flag", 512'(kb_out_dak_zero), 0);
    @(posedge clk); #1;

    // Backpressure over two records.
    kb_out_ack = 1'b0;
    for (int i = 0; i < 12; i++) cur[i] = 64'h100 + 64'(i);
    send_beats(12, 1'b1);
    chk("bp_a_valid", 512'(kb_out_valid), 1);
    chk("bp_a_stall", 512'(keybuilder_kdf_stall), 0);
    for (int i = 0; i < 12; i++) cur[i] = 64'h200 + 64'(i);
    send_beats(11, 1'b1);
    chk("bp_stall_before_last", 512'(keybuilder_kdf_stall), 0);
    kdf_keybuilder_valid = 1'b1;
    kdf_keybuilder_data  = cur[11];
    @(posedge clk); #1;
    kdf_keybuilder_valid = 1'b0;
    chk("bp_stall_full", 512'(keybuilder_kdf_stall), 1);
    chk("bp_held_dek", 512'(kb_out_dek[511:448]), 512'h100);
    kdf_keybuilder_valid = 1'b1;
    kdf_keybuilder_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    kdf_keybuilder_valid = 1'b0;
    chk("bp_stall_drop", 512'(keybuilder_kdf_stall), 1);
    kb_out_ack = 1'b1;
    @(posedge clk); #1;
    kb_out_ack = 1'b0;
    chk("bp_b_valid", 512'(kb_out_valid), 1);
    chk("bp_b_stall", 512'(keybuilder_kdf_stall), 0);
    chk("bp_b_dek", 512'(kb_out_dek[511:448]), 512'h200);
    kb_out_ack = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_consumed", 512'(kb_out_valid), 0);
    chk("bp_cnt", 512'(kb_rec_count), 4);

    // Reset in the middle of a record.
    for (int i = 0; i < 12; i++) cur[i] = 64'hBAD0 + 64'(i);
    send_beats(6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 512'(kb_out_valid), 0);
    chk("mrst_stall", 512'(keybuilder_kdf_stall), 0);
    chk("mrst_dek", kb_out_dek, 0);
    chk("mrst_dak", 512'(kb_out_dak), 0);
    chk("mrst_flags", 512'({kb_out_dek_zero, kb_out_dak_zero}), 0);
    chk("mrst_cnt", 512'(kb_rec_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) cur[i] = 64'h3000 + 64'(i);
    send_beats(12, 1'b1);
    chk("mrst_clean_beat0", 512'(kb_out_dek[511:448]), 512'h3000);
    @(posedge clk); #1;
    chk("mrst_cnt_after", 512'(kb_rec_count), 1);

    // 1000 records at full rate.
    pulse_reset();
    tput_on = 1'b1;
    last_hs = -1;
    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < 12; i++) begin
        if (r % 97 == 0)                 cur[i] = 64'h0;
        else if (i >= 8 && r % 50 == 3)  cur[i] = 64'h0;
        else cur[i] = {16'hA5A5, 16'(r), 16'(i), 16'h5A5A};
      end
      send_beats(12, 1'b1);
    end
    @(posedge clk); #1;
    tput_on = 1'b0;
    chk("tput_cnt", 512'(kb_rec_count), 1000);
    chk("tput_sb_empty", 512'(sb.size()), 0);

    // Counter wrap.
    force dut.kb_rec_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.kb_rec_count;
    @(posedge clk); #1;
    chk("wrap_pre", 512'(kb_rec_count), 512'hFFFF);
    for (int i = 0; i < 12; i++) cur[i] = 64'h7700 + 64'(i);
    send_beats(12, 1'b1);
    @(posedge clk); #1;
    chk("wrap_cnt", 512'(kb_rec_count), 0);
    chk("final_sb_empty", 512'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
